// File: rtl/storage_arbiter_if.sv
// Bundle of requester, programming-mode and storage_controller signals around storage_arbiter.
// The slave view is the arbiter; the master view is the fetch/LSU plus memory side.
interface storage_arbiter_if;
  logic        prog_mode;
  logic        arb_idle;

  logic        iport_req;
  logic [31:0] iport_addr;
  logic        iport_ack;
  logic [31:0] iport_rdata;
  logic        iport_err;

  logic        dport_req;
  logic        dport_we;
  logic [31:0] dport_addr;
  logic [31:0] dport_wdata;
  logic [3:0]  dport_be;
  logic        dport_ack;
  logic [31:0] dport_rdata;
  logic        dport_err;

  logic        memory_access;
  logic        memory_is_writing;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [3:0]  mem_be;
  logic [31:0] d_out;
  logic        out_valid;

  modport slave (
    input  prog_mode, iport_req, iport_addr,
           dport_req, dport_we, dport_addr, dport_wdata, dport_be,
           d_out, out_valid,
    output arb_idle, iport_ack, iport_rdata, iport_err,
           dport_ack, dport_rdata, dport_err,
           memory_access, memory_is_writing, addr, d_in, mem_be
  );

  modport master (
    output prog_mode, iport_req, iport_addr,
           dport_req, dport_we, dport_addr, dport_wdata, dport_be,
           d_out, out_valid,
    input  arb_idle, iport_ack, iport_rdata, iport_err,
           dport_ack, dport_rdata, dport_err,
           memory_access, memory_is_writing, addr, d_in, mem_be
  );
endinterface

// File: rtl/storage_arbiter.sv
// Round-robin arbiter sharing the storage_controller port between instruction fetch and data.
// state  | meaning
// IDLE   | waiting for a request; grants blocked while prog_mode is high
// ACCESS | memory_access asserted, waiting for out_valid or timeout
// RESP   | one-cycle ack to the granted port
module storage_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  storage_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_d;
  logic            gnt_d;
  logic [CW-1:0]   cnt;
  logic            grant;
  logic            pick_d;
  logic            skip;
  logic            timeout;
  logic            done;

  always_comb begin
    grant     = (bus.iport_req | bus.dport_req) & ~bus.prog_mode;
    // On a tie the port opposite the previous grant wins.
    pick_d    = bus.dport_req & (~bus.iport_req | ~last_d);
    skip      = pick_d & bus.dport_we & (bus.dport_be == 4'h0);
    timeout   = (cnt == CNT_LAST);
    done      = bus.out_valid | timeout;
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = skip ? RESP : ACCESS;
      ACCESS:  if (done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d                <= 1'b0;
      gnt_d                 <= 1'b0;
      cnt                   <= '0;
      bus.arb_idle          <= 1'b1;
      bus.iport_ack         <= 1'b0;
      bus.iport_rdata       <= '0;
      bus.iport_err         <= 1'b0;
      bus.dport_ack         <= 1'b0;
      bus.dport_rdata       <= '0;
      bus.dport_err         <= 1'b0;
      bus.memory_access     <= 1'b0;
      bus.memory_is_writing <= 1'b0;
      bus.addr              <= '0;
      bus.d_in              <= '0;
      bus.mem_be            <= '0;
    end else begin
      bus.iport_ack <= 1'b0;
      bus.dport_ack <= 1'b0;
      bus.arb_idle  <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (grant) begin
            last_d <= pick_d;
            gnt_d  <= pick_d;
            cnt    <= '0;
            if (skip) begin
              bus.dport_ack <= 1'b1;
              bus.dport_err <= 1'b0;
            end else begin
              bus.memory_access <= 1'b1;
              if (pick_d) begin
                bus.memory_is_writing <= bus.dport_we;
                bus.addr              <= bus.dport_addr;
                bus.d_in              <= bus.dport_wdata;
                bus.mem_be            <= bus.dport_be;
              end else begin
                bus.memory_is_writing <= 1'b0;
                bus.addr              <= bus.iport_addr;
                bus.d_in              <= '0;
                bus.mem_be            <= 4'hF;
              end
            end
          end
        end
        ACCESS: begin
          if (done) begin
            bus.memory_access     <= 1'b0;
            bus.memory_is_writing <= 1'b0;
            bus.addr              <= '0;
            bus.d_in              <= '0;
            bus.mem_be            <= '0;
            // out_valid takes priority over a coincident timeout.
            if (gnt_d) begin
              bus.dport_ack   <= 1'b1;
              bus.dport_rdata <= bus.out_valid ? bus.d_out : 32'h0;
              bus.dport_err   <= ~bus.out_valid;
            end else begin
              bus.iport_ack   <= 1'b1;
              bus.iport_rdata <= bus.out_valid ? bus.d_out : 32'h0;
              bus.iport_err   <= ~bus.out_valid;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter with an 8-cycle timeout and a scripted memory responder.
module tb_storage_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   valid_at = 0;
  int   acc_cyc = 0;

  storage_arbiter_if bus ();

  storage_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Responder: out_valid in the valid_at-th ACCESS cycle (0 = never), data = addr + 1.
  always @(posedge clk) acc_cyc <= bus.memory_access ? acc_cyc + 1 : 0;
  assign bus.out_valid = bus.memory_access && (valid_at != 0) && (acc_cyc == valid_at - 1);
  assign bus.d_out     = bus.addr + 32'h1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.prog_mode = 0; bus.iport_req = 0; bus.iport_addr = 0;
    bus.dport_req = 0; bus.dport_we = 0; bus.dport_addr = 0;
    bus.dport_wdata = 0; bus.dport_be = 0;
    rst = 1;
    tick(); tick();
    vecs++; if (bus.memory_access !== 1'b0) begin errs++; $display("FAIL reset_ma: got %b exp 0", bus.memory_access); end
    vecs++; if (bus.arb_idle !== 1'b1) begin errs++; $display("FAIL reset_idle: got %b exp 1", bus.arb_idle); end
    vecs++; if ({bus.iport_ack, bus.dport_ack, bus.iport_err, bus.dport_err} !== 4'b0) begin
      errs++; $display("FAIL reset_acks: got %b exp 0000", {bus.iport_ack, bus.dport_ack, bus.iport_err, bus.dport_err}); end
    vecs++; if (bus.addr !== 32'h0) begin errs++; $display("FAIL reset_addr: got %h exp 0", bus.addr); end
    rst = 0;
    tick();
  endtask

  task automatic test_data_write();
    valid_at = 1;
    bus.dport_req = 1; bus.dport_we = 1; bus.dport_addr = 32'h10;
    bus.dport_wdata = 32'hDEADBEEF; bus.dport_be = 4'hF;
    tick();
    vecs++; if ({bus.memory_access, bus.memory_is_writing} !== 2'b11) begin
      errs++; $display("FAIL wr_ctrl: got %b exp 11", {bus.memory_access, bus.memory_is_writing}); end
    vecs++; if (bus.addr !== 32'h10) begin errs++; $display("FAIL wr_addr: got %h exp 10", bus.addr); end
    vecs++; if (bus.d_in !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_din: got %h exp deadbeef", bus.d_in); end
    vecs++; if (bus.mem_be !== 4'hF) begin errs++; $display("FAIL wr_be: got %h exp f", bus.mem_be); end
    vecs++; if (bus.arb_idle !== 1'b0) begin errs++; $display("FAIL wr_busy: got %b exp 0", bus.arb_idle); end
    tick();
    vecs++; if ({bus.dport_ack, bus.dport_err, bus.memory_access} !== 3'b100) begin
      errs++; $display("FAIL wr_ack: got %b exp 100", {bus.dport_ack, bus.dport_err, bus.memory_access}); end
    vecs++; if (bus.dport_rdata !== 32'h11) begin errs++; $display("FAIL wr_rdata: got %h exp 11", bus.dport_rdata); end
    bus.dport_req = 0;
    tick();
    vecs++; if ({bus.dport_ack, bus.arb_idle} !== 2'b01) begin
      errs++; $display("FAIL wr_end: got %b exp 01", {bus.dport_ack, bus.arb_idle}); end
  endtask

  task automatic test_tie();
    rst = 1; tick(); rst = 0;
    valid_at = 1;
    bus.iport_req = 1; bus.iport_addr = 32'h100;
    bus.dport_req = 1; bus.dport_we = 0; bus.dport_addr = 32'h200; bus.dport_be = 4'hF;
    tick();
    vecs++; if (bus.addr !== 32'h200) begin errs++; $display("FAIL tie1_addr: got %h exp 200", bus.addr); end
    tick();
    vecs++; if ({bus.dport_ack, bus.iport_ack} !== 2'b10) begin
      errs++; $display("FAIL tie1_ack: got %b exp 10", {bus.dport_ack, bus.iport_ack}); end
    vecs++; if (bus.dport_rdata !== 32'h201) begin errs++; $display("FAIL tie1_rdata: got %h exp 201", bus.dport_rdata); end
    bus.dport_req = 0;
    tick();
    tick();
    vecs++; if ({bus.addr, bus.mem_be, bus.memory_is_writing} !== {32'h100, 4'hF, 1'b0}) begin
      errs++; $display("FAIL fetch_out: got %h/%h/%b exp 100/f/0", bus.addr, bus.mem_be, bus.memory_is_writing); end
    tick();
    vecs++; if ({bus.iport_ack, bus.dport_ack} !== 2'b10) begin
      errs++; $display("FAIL fetch_ack: got %b exp 10", {bus.iport_ack, bus.dport_ack}); end
    vecs++; if (bus.iport_rdata !== 32'h101) begin errs++; $display("FAIL fetch_rdata: got %h exp 101", bus.iport_rdata); end
    vecs++; if (bus.dport_rdata !== 32'h201) begin errs++; $display("FAIL d_hold: got %h exp 201", bus.dport_rdata); end
    bus.dport_req = 1; bus.dport_addr = 32'h300;
    tick();
    tick();
    vecs++; if (bus.addr !== 32'h300) begin errs++; $display("FAIL tie2_addr: got %h exp 300", bus.addr); end
    tick();
    vecs++; if ({bus.dport_ack, bus.dport_rdata} !== {1'b1, 32'h301}) begin
      errs++; $display("FAIL tie2_ack: got %b/%h exp 1/301", bus.dport_ack, bus.dport_rdata); end
    bus.dport_req = 0; bus.iport_req = 0;
    tick();
  endtask

  task automatic run_timeout(input int vat, input logic [31:0] a, input logic [31:0] exp_rdata,
                             input logic exp_err);
    int  ma = 0;
    bit  got = 0;
    valid_at = vat;
    bus.dport_req = 1; bus.dport_we = 0; bus.dport_addr = a; bus.dport_be = 4'hF;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (bus.memory_access) ma++;
      if (bus.dport_ack) begin got = 1; break; end
      tick();
    end
    bus.dport_req = 0;
    vecs++; if (!got) begin errs++; $display("FAIL to_ack_seen: got 0 exp 1"); end
    vecs++; if (ma != 8) begin errs++; $display("FAIL to_ma_cycles: got %0d exp 8", ma); end
    vecs++; if ({bus.dport_err, bus.dport_rdata} !== {exp_err, exp_rdata}) begin
      errs++; $display("FAIL to_resp: got %b/%h exp %b/%h", bus.dport_err, bus.dport_rdata, exp_err, exp_rdata); end
    tick();
  endtask

  task automatic test_zero_be();
    bus.dport_req = 1; bus.dport_we = 1; bus.dport_addr = 32'h80; bus.dport_be = 4'h0;
    tick();
    vecs++; if ({bus.dport_ack, bus.dport_err, bus.memory_access, bus.arb_idle} !== 4'b1000) begin
      errs++; $display("FAIL zbe_ack: got %b exp 1000", {bus.dport_ack, bus.dport_err, bus.memory_access, bus.arb_idle}); end
    bus.dport_req = 0;
    tick();
    vecs++; if ({bus.dport_ack, bus.memory_access, bus.arb_idle} !== 3'b001) begin
      errs++; $display("FAIL zbe_end: got %b exp 001", {bus.dport_ack, bus.memory_access, bus.arb_idle}); end
  endtask

  task automatic test_prog_mode();
    bit bad = 0;
    bit got = 0;
    valid_at = 3;
    bus.prog_mode = 1; bus.iport_req = 1; bus.iport_addr = 32'h500;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.memory_access !== 1'b0 || bus.arb_idle !== 1'b1) bad = 1;
    end
    vecs++; if (bad) begin errs++; $display("FAIL pm_hold: got grant exp none"); end
    bus.prog_mode = 0;
    tick();
    vecs++; if ({bus.memory_access, bus.addr} !== {1'b1, 32'h500}) begin
      errs++; $display("FAIL pm_release: got %b/%h exp 1/500", bus.memory_access, bus.addr); end
    bus.prog_mode = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.iport_ack) begin got = 1; break; end
    end
    vecs++; if ({got, bus.iport_rdata} !== {1'b1, 32'h501}) begin
      errs++; $display("FAIL pm_inflight: got %b/%h exp 1/501", got, bus.iport_rdata); end
    bus.iport_req = 0;
    tick();
    vecs++; if ({bus.arb_idle, bus.memory_access} !== 2'b10) begin
      errs++; $display("FAIL pm_idle: got %b exp 10", {bus.arb_idle, bus.memory_access}); end
    bus.prog_mode = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    valid_at = 0;
    bus.dport_req = 1; bus.dport_we = 0; bus.dport_addr = 32'h600; bus.dport_be = 4'hF;
    tick();
    tick();
    vecs++; if (bus.memory_access !== 1'b1) begin errs++; $display("FAIL rm_busy: got %b exp 1", bus.memory_access); end
    rst = 1;
    tick();
    vecs++; if ({bus.memory_access, bus.arb_idle, bus.iport_ack, bus.dport_ack} !== 4'b0100) begin
      errs++; $display("FAIL rm_abort: got %b exp 0100", {bus.memory_access, bus.arb_idle, bus.iport_ack, bus.dport_ack}); end
    tick();
    vecs++; if ({bus.iport_ack, bus.dport_ack} !== 2'b00) begin
      errs++; $display("FAIL rm_noack: got %b exp 00", {bus.iport_ack, bus.dport_ack}); end
    rst = 0; valid_at = 1; bus.dport_addr = 32'h700;
    tick();
    vecs++; if ({bus.memory_access, bus.addr} !== {1'b1, 32'h700}) begin
      errs++; $display("FAIL rm_next: got %b/%h exp 1/700", bus.memory_access, bus.addr); end
    tick();
    vecs++; if ({bus.dport_ack, bus.dport_err, bus.dport_rdata} !== {2'b10, 32'h701}) begin
      errs++; $display("FAIL rm_next_ack: got %b/%b/%h exp 1/0/701", bus.dport_ack, bus.dport_err, bus.dport_rdata); end
    bus.dport_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_tie();
    run_timeout(0, 32'h40, 32'h0, 1'b1);
    test_zero_be();
    run_timeout(8, 32'h44, 32'h45, 1'b0);
    test_prog_mode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
